// File: rtl/fetch_queue.sv
// fetch_queue: PC holder, single-outstanding instruction-memory requester and
// prefetch FIFO feeding decode over valid/ready.
// Optional build macro: FETCH_MISALIGN_TRAP_EN adds a sticky 'misaligned'
// output and forces redirect targets onto a PC_STEP boundary.
//
// state  | meaning
// S_IDLE | no request outstanding; may issue when FIFO has space
// S_WAIT | one request outstanding; next response completes it
module fetch_queue #(
  parameter int ADDRESS_BITS = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int PC_STEP      = 4,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            next_PC_select,
  input  logic [ADDRESS_BITS-1:0]         target_PC,
  output logic                            imem_req_valid,
  input  logic                            imem_req_ready,
  output logic [ADDRESS_BITS-1:0]         imem_req_addr,
  input  logic                            imem_resp_valid,
  input  logic [DATA_WIDTH-1:0]           imem_resp_data,
  output logic                            inst_valid,
  input  logic                            inst_ready,
  output logic [DATA_WIDTH-1:0]           inst_data,
  output logic [ADDRESS_BITS-1:0]         inst_PC,
  output logic [ADDRESS_BITS-1:0]         PC,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                            misaligned,
`endif
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDRESS_BITS-1:0] STEP = ADDRESS_BITS'(PC_STEP);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_discard;
  logic                    w_discard_nxt;
  logic                    w_req_valid;
  logic                    w_req_fire;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic [ADDRESS_BITS-1:0] r_pc;
  logic [ADDRESS_BITS-1:0] r_cap;
  logic [ADDRESS_BITS-1:0] w_target;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [DATA_WIDTH-1:0]   r_mem_data [FIFO_DEPTH];
  logic [ADDRESS_BITS-1:0] r_mem_pc   [FIFO_DEPTH];

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [ADDRESS_BITS-1:0] STEP_MASK = ADDRESS_BITS'(PC_STEP - 1);
  logic r_misaligned;

  assign w_target   = target_PC & ~STEP_MASK;
  assign misaligned = r_misaligned;

  // Sticky trap flag: any redirect to an unaligned target sets it until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_misaligned <= 1'b0;
    end else if (next_PC_select && ((target_PC & STEP_MASK) != '0)) begin
      r_misaligned <= 1'b1;
    end
  end
`else
  assign w_target = target_PC;
`endif

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_req_fire = w_req_valid & imem_req_ready;
  assign w_pop      = (r_count != '0) & inst_ready;

  // FSM state and discard flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  // Next state, request valid and response acceptance. Request valid is gated
  // by reset so nothing is offered while reset is held.
  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    w_req_valid   = 1'b0;
    w_push        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_valid = reset & ~w_full & ~next_PC_select;
        if (w_req_valid && imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          w_push        = ~r_discard & ~next_PC_select;
          w_discard_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end else if (next_PC_select) begin
          w_discard_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_discard_nxt = 1'b0;
      end
    endcase
  end

  // PC update: redirect wins over sequential advance; capture issued address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc  <= RESET_PC;
      r_cap <= '0;
    end else if (next_PC_select) begin
      r_pc <= w_target;
    end else if (w_req_fire) begin
      r_pc  <= r_pc + STEP;
      r_cap <= r_pc;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (next_PC_select) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= imem_resp_data;
      r_mem_pc[r_wr_ptr]   <= r_cap;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign PC             = r_pc;
  assign inst_valid     = (r_count != '0);
  assign inst_data      = r_mem_data[r_rd_ptr];
  assign inst_PC        = r_mem_pc[r_rd_ptr];
  assign fifo_count     = r_count;

endmodule
